mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 4K x 12 main-memory port between two requesters: the CPU controller (instruction fetch, operand, indirect, autoindex and EAE accesses) and a data-break (DMA) requester.
- Sits between both requesters and the memory module.
- Latches the winning request, drives the memory port for the full multi-cycle access, and returns read data with a one-cycle finished pulse to the winner.
- Data break has priority, bounded by an anti-starvation limit for the CPU.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 12, memory word width
STARVE_LIMIT, 4, max consecutive DMA grants while CPU request pending (range 1-15)

Ports:
clock  input  1  system clock, all state on rising edge
resetN  input  1  asynchronous, active-low reset
cpu_read_enable  input  1  CPU read request, level, held until cpu_mem_finished
cpu_write_enable  input  1  CPU write request, level, held until cpu_mem_finished
cpu_address  input  ADDR_W  CPU access address
cpu_write_data  input  DATA_W  CPU write data
cpu_read_data  output  DATA_W  registered read data for CPU
cpu_mem_finished  output  1  one-cycle CPU completion pulse
dma_req  input  1  DMA request, level, held until dma_done
dma_we  input  1  DMA direction: 1 write, 0 read
dma_address  input  ADDR_W  DMA access address
dma_write_data  input  DATA_W  DMA write data
dma_read_data  output  DATA_W  registered read data for DMA
dma_done  output  1  one-cycle DMA completion pulse
mem_read_enable  output  1  to memory, held for whole read
mem_write_enable  output  1  to memory, held for whole write
mem_address  output  ADDR_W  to memory
mem_write_data  output  DATA_W  to memory
mem_read_data  input  DATA_W  from memory, valid when mem_finished=1
mem_finished  input  1  memory completion, one or more cycles after enable
owner  output  1  0 CPU / idle, 1 DMA transfer in progress
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (asynchronous, resetN=0):
  - State goes to IDLE; streak counter clears to 0.
  - All outputs go to 0 immediately, including mem enables, address, write data, both read-data registers, both finished pulses, owner and busy.
  - A memory access in flight is abandoned. No finished pulse is issued for it after reset releases.
- States: IDLE, CPU_XFER, DMA_XFER, RELEASE.
- IDLE:
  - cpu_req = cpu_read_enable | cpu_write_enable.
  - Both requesting: grant DMA if streak < STARVE_LIMIT, else grant CPU.
  - Only one requesting: grant that requester.
  - On grant, register address, write data and direction into mem_* (registered outputs) and assert the memory enable from the next cycle.
  - Next state is CPU_XFER or DMA_XFER.
- CPU direction: cpu_read_enable and cpu_write_enable both high means a write is performed.
- Streak counter: increments, saturating at 15, on each DMA grant made while cpu_req=1. Clears on every CPU grant. Unchanged otherwise.
- CPU_XFER / DMA_XFER:
  - Enable, address and data are held constant, ignoring requester input changes.
  - owner=1 only in DMA_XFER and in the RELEASE that follows it.
  - When mem_finished=1: capture mem_read_data into the owner's read-data register (reads only; unchanged on writes), drop the memory enable on that edge, and go to RELEASE.
- RELEASE (exactly 1 cycle):
  - The owner's finished pulse (cpu_mem_finished or dma_done) is high for this one cycle only.
  - Read data is valid in the same cycle and held until the next read completion for that requester.
  - Next state is IDLE. No grant is made in RELEASE, so a requester that drops its request in response to finished is never re-granted.
- Latency: request high at rising edge k in IDLE gives memory enable high in cycle k+1. mem_finished at edge m gives the finished pulse in cycle m+1. Arbitration overhead is 2 cycles per access (grant plus release).
- No preemption: a DMA request arriving during CPU_XFER waits for IDLE.
- mem_finished outside an XFER state is ignored.
- A request dropped mid-transfer does not abort the transfer. The transfer completes and the finished pulse is still issued.

Test Plan:
1. CPU-only read: cpu_read_enable=1, cpu_address=0o0200, memory returns 0o7402 after 3 cycles -> mem_read_enable high 3 cycles, mem_address=0o0200, cpu_mem_finished single pulse, cpu_read_data=0o7402, owner=0 throughout.
2. CPU write: cpu_write_enable=1, address 0o0010, data 0o1234 -> mem_write_enable held until mem_finished, mem_write_data=0o1234, cpu_read_data unchanged, single cpu_mem_finished pulse.
3. Simultaneous requests: CPU read 0o0100 and DMA write 0o2000/0o5555 raised on the same edge -> DMA served first (owner=1), dma_done pulse, then CPU granted; CPU result correct.
4. Starvation bound: dma_req held continuously with cpu_read_enable high, STARVE_LIMIT=4 -> exactly 4 DMA transfers, then 1 CPU transfer, then DMA resumes; streak reads 0 after the CPU grant.
5. Reset mid-transfer: resetN low during DMA_XFER -> mem enables, owner and busy drop asynchronously. After release, no dma_done pulse and state is IDLE; a new CPU read completes normally.
6. Both CPU enables high, address 0o0300, data 0o0007 -> write performed, mem_read_enable stays 0 for the entire access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-way arbiter for the shared main-memory port: data break (DMA) wins ties,
// but the CPU is guaranteed a grant after STARVE_LIMIT consecutive contested DMA grants.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              cpu_read_enable,
  input  logic              cpu_write_enable,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_mem_finished,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_write_data,
  output logic [DATA_W-1:0] dma_read_data,
  output logic              dma_done,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_finished,
  output logic              owner,
  output logic              busy
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StCpuXfer, StDmaXfer, StRelease} state_e;

  state_e              state_q, state_d;
  logic                dma_owner_q, dma_owner_d;
  logic [3:0]          streak_q, streak_d;
  logic                mem_re_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_d, dma_rdata_d;
  logic                cpu_req;

  assign cpu_req = cpu_read_enable | cpu_write_enable;

  always_comb begin
    state_d     = state_q;
    dma_owner_d = dma_owner_q;
    streak_d    = streak_q;
    mem_re_d    = mem_read_enable;
    mem_we_d    = mem_write_enable;
    mem_addr_d  = mem_address;
    mem_wdata_d = mem_write_data;
    cpu_rdata_d = cpu_read_data;
    dma_rdata_d = dma_read_data;

    unique case (state_q)
      StIdle: begin
        if (dma_req && (!cpu_req || (streak_q < StarveMax))) begin
          state_d     = StDmaXfer;
          dma_owner_d = 1'b1;
          mem_re_d    = ~dma_we;
          mem_we_d    = dma_we;
          mem_addr_d  = dma_address;
          mem_wdata_d = dma_write_data;
          if (cpu_req && (streak_q != 4'hF)) streak_d = streak_q + 4'd1;
        end else if (cpu_req) begin
          state_d     = StCpuXfer;
          dma_owner_d = 1'b0;
          // Both CPU enables high is a write.
          mem_re_d    = ~cpu_write_enable;
          mem_we_d    = cpu_write_enable;
          mem_addr_d  = cpu_address;
          mem_wdata_d = cpu_write_data;
          streak_d    = 4'd0;
        end
      end
      StCpuXfer, StDmaXfer: begin
        if (mem_finished) begin
          if (mem_read_enable) begin
            if (dma_owner_q) dma_rdata_d = mem_read_data;
            else             cpu_rdata_d = mem_read_data;
          end
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q          <= StIdle;
      dma_owner_q      <= 1'b0;
      streak_q         <= 4'd0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      cpu_read_data    <= '0;
      dma_read_data    <= '0;
    end else begin
      state_q          <= state_d;
      dma_owner_q      <= dma_owner_d;
      streak_q         <= streak_d;
      mem_read_enable  <= mem_re_d;
      mem_write_enable <= mem_we_d;
      mem_address      <= mem_addr_d;
      mem_write_data   <= mem_wdata_d;
      cpu_read_data    <= cpu_rdata_d;
      dma_read_data    <= dma_rdata_d;
    end
  end

  always_comb begin
    busy             = (state_q != StIdle);
    owner            = (state_q == StDmaXfer) || ((state_q == StRelease) && dma_owner_q);
    cpu_mem_finished = (state_q == StRelease) && !dma_owner_q;
    dma_done         = (state_q == StRelease) && dma_owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model plus a
// scoreboard of expected accesses checked on every enable cycle and completion.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        resetN;
  logic        cpu_read_enable, cpu_write_enable;
  logic [11:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        cpu_mem_finished;
  logic        dma_req, dma_we;
  logic [11:0] dma_address, dma_write_data, dma_read_data;
  logic        dma_done;
  logic        mem_read_enable, mem_write_enable;
  logic [11:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_finished;
  logic        owner, busy;

  mem_arbiter #(.ADDR_W(12), .DATA_W(12), .STARVE_LIMIT(4)) dut (
    .clock(clock), .resetN(resetN),
    .cpu_read_enable(cpu_read_enable), .cpu_write_enable(cpu_write_enable),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_mem_finished(cpu_mem_finished),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address),
    .dma_write_data(dma_write_data), .dma_read_data(dma_read_data), .dma_done(dma_done),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_finished(mem_finished),
    .owner(owner), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_dma;
    bit          is_write;
    logic [11:0] addr;
    logic [11:0] data;   // write data, or expected read data
  } acc_t;

  acc_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          lat = 3;
  int          mem_cnt = 0;
  int          cur_en_cycles = 0;
  int          last_en_cycles = 0;
  logic [11:0] mem_model [4096];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  // Memory model: completes lat cycles after the enable rises.
  always @(negedge clock) begin
    if (!resetN) begin
      mem_cnt      = 0;
      mem_finished = 1'b0;
    end else if ((mem_read_enable || mem_write_enable) && !mem_finished) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin
        mem_cnt       = 0;
        mem_finished  = 1'b1;
        mem_read_data = mem_model[mem_address];
        if (mem_write_enable) mem_model[mem_address] = mem_write_data;
      end
    end else begin
      mem_finished = 1'b0;
    end
  end

  always @(negedge clock) begin
    acc_t e;
    if (!resetN) begin
      cur_en_cycles = 0;
    end else begin
      if (mem_read_enable || mem_write_enable) begin
        check("access_expected", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
          e = sb[0];
          check("mem_address", 16'(mem_address), 16'(e.addr));
          check("mem_write_enable", 16'(mem_write_enable), 16'(e.is_write));
          check("mem_read_enable", 16'(mem_read_enable), 16'(!e.is_write));
          check("owner_xfer", 16'(owner), 16'(e.is_dma));
          check("busy_xfer", 16'(busy), 16'd1);
          if (e.is_write) check("mem_write_data", 16'(mem_write_data), 16'(e.data));
        end
        cur_en_cycles++;
      end
      if (cpu_mem_finished || dma_done) begin
        check("finish_expected", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("dma_done", 16'(dma_done), 16'(e.is_dma));
          check("cpu_mem_finished", 16'(cpu_mem_finished), 16'(!e.is_dma));
          check("owner_release", 16'(owner), 16'(e.is_dma));
          check("enables_off", 16'({mem_read_enable, mem_write_enable}), 16'd0);
          if (!e.is_write && e.is_dma)  check("dma_read_data", 16'(dma_read_data), 16'(e.data));
          if (!e.is_write && !e.is_dma) check("cpu_read_data", 16'(cpu_read_data), 16'(e.data));
        end
        last_en_cycles = cur_en_cycles;
        cur_en_cycles  = 0;
      end
    end
  end

  // Requesters drop on their finished pulse; DMA stays up for dma_extra more transfers.
  task automatic run(input int dma_extra, input int max_cyc);
    int keep = dma_extra;
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      #1;
      if (cpu_mem_finished) begin
        cpu_read_enable  = 1'b0;
        cpu_write_enable = 1'b0;
      end
      if (dma_done) begin
        if (keep > 0) keep--;
        else dma_req = 1'b0;
      end
      if (sb.size() == 0 && !cpu_read_enable && !cpu_write_enable && !dma_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("run_timeout", 16'(ok), 16'd1);
  endtask

  task automatic push(input bit d, input bit w, input logic [11:0] a, input logic [11:0] v);
    acc_t e;
    e.is_dma = d; e.is_write = w; e.addr = a; e.data = v;
    sb.push_back(e);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 4096; i++) mem_model[i] = 12'(i ^ 12'o5252);
    mem_model[12'o0200] = 12'o7402;
    mem_model[12'o0100] = 12'o4321;
    resetN = 1'b0;
    cpu_read_enable = 0; cpu_write_enable = 0; cpu_address = 0; cpu_write_data = 0;
    dma_req = 0; dma_we = 0; dma_address = 0; dma_write_data = 0;
    mem_read_data = 0; mem_finished = 0;
    #12;
    check("rst_outputs", 16'({mem_read_enable, mem_write_enable, owner, busy,
                              cpu_mem_finished, dma_done}), 16'd0);
    check("rst_mem_address", 16'(mem_address), 16'd0);
    check("rst_cpu_read_data", 16'(cpu_read_data), 16'd0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    // 1: CPU-only read
    cpu_read_enable = 1; cpu_address = 12'o0200;
    push(0, 0, 12'o0200, 12'o7402);
    run(0, 40);
    check("t1_en_cycles", 16'(last_en_cycles), 16'd3);
    @(negedge clock);
    check("t1_pulse_single", 16'(cpu_mem_finished), 16'd0);
    check("t1_idle", 16'(busy), 16'd0);

    // 2: CPU write, read register must hold previous value
    cpu_write_enable = 1; cpu_address = 12'o0010; cpu_write_data = 12'o1234;
    push(0, 1, 12'o0010, 12'o1234);
    run(0, 40);
    check("t2_cpu_read_data_kept", 16'(cpu_read_data), 16'o7402);
    check("t2_mem_written", 16'(mem_model[12'o0010]), 16'o1234);

    // 3: simultaneous requests, DMA first
    cpu_read_enable = 1; cpu_address = 12'o0100;
    dma_req = 1; dma_we = 1; dma_address = 12'o2000; dma_write_data = 12'o5555;
    push(1, 1, 12'o2000, 12'o5555);
    push(0, 0, 12'o0100, 12'o4321);
    run(0, 60);

    // 4: starvation bound: 4 DMA, 1 CPU, then DMA again
    lat = 2;
    cpu_read_enable = 1; cpu_address = 12'o0200;
    dma_req = 1; dma_we = 0; dma_address = 12'o2000;
    for (int i = 0; i < 4; i++) push(1, 0, 12'o2000, 12'o5555);
    push(0, 0, 12'o0200, 12'o7402);
    push(1, 0, 12'o2000, 12'o5555);
    run(4, 200);

    // 5: reset during a DMA read
    lat = 6;
    dma_req = 1; dma_we = 0; dma_address = 12'o0100;
    push(1, 0, 12'o0100, 12'o4321);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = mem_read_enable;
    end
    check("t5_enable_seen", 16'(seen), 16'd1);
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    check("t5_async_drop", 16'({mem_read_enable, mem_write_enable, owner, busy}), 16'd0);
    check("t5_dma_read_data_rst", 16'(dma_read_data), 16'd0);
    sb.delete();
    dma_req = 0;
    @(negedge clock);
    #2 resetN = 1'b1;
    repeat (10) @(negedge clock);
    check("t5_idle_after", 16'(busy), 16'd0);
    lat = 3;
    cpu_read_enable = 1; cpu_address = 12'o0200;
    push(0, 0, 12'o0200, 12'o7402);
    run(0, 40);

    // 6: both CPU enables -> write, read enable never high
    cpu_read_enable = 1; cpu_write_enable = 1; cpu_address = 12'o0300; cpu_write_data = 12'o0007;
    push(0, 1, 12'o0300, 12'o0007);
    run(0, 40);
    check("t6_mem_written", 16'(mem_model[12'o0300]), 16'o0007);
    cpu_read_enable = 1; cpu_address = 12'o0300;
    push(0, 0, 12'o0300, 12'o0007);
    run(0, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
